// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, loads it from a two-word vector table on request
// and streams instructions from a synchronous 16-bit memory with stall and branch redirect.
module pc_fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] VEC_BASE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch,
    input  logic              extend,
    input  logic [1:0]        fetch_src,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [31:0]       branch_target,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_en,
    input  logic [15:0]       imem_rdata,
    output logic [15:0]       inst_out,
    output logic [31:0]       inst_pc,
    output logic              inst_valid,
    output logic [31:0]       epc,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        VEC_HI  = 2'd2,
        VEC_END = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       inst_pc_q, inst_pc_d;
    logic [31:0]       epc_q, epc_d;
    logic [15:0]       lo_half_q, lo_half_d;
    logic              rd_valid_q, rd_valid_d;
    logic [ADDR_W-1:0] vec_q, vec_d;

    logic              vec_start_s;
    logic [ADDR_W-1:0] vec_addr_s;
    logic              imem_en_s;
    logic [ADDR_W-1:0] imem_addr_s;

    assign vec_addr_s  = VEC_BASE + ADDR_W'({fetch_src, 1'b0});
    assign vec_start_s = fetch && ((state_q == IDLE) || (state_q == RUN));

    // State and datapath registers; reset aborts any vector load in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= 32'h0;
            inst_pc_q  <= 32'h0;
            epc_q      <= 32'h0;
            lo_half_q  <= 16'h0;
            rd_valid_q <= 1'b0;
            vec_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_pc_q  <= inst_pc_d;
            epc_q      <= epc_d;
            lo_half_q  <= lo_half_d;
            rd_valid_q <= rd_valid_d;
            vec_q      <= vec_d;
        end
    end

    // Next-state, datapath updates and memory request for the current cycle.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_pc_d   = inst_pc_q;
        epc_d       = epc_q;
        lo_half_d   = lo_half_q;
        rd_valid_d  = rd_valid_q;
        vec_d       = vec_q;
        imem_en_s   = 1'b0;
        imem_addr_s = pc_q[ADDR_W-1:0];

        if (vec_start_s) begin
            // The word in flight is dropped; epc records where execution would have resumed.
            imem_addr_s = vec_addr_s;
            imem_en_s   = 1'b1;
            rd_valid_d  = 1'b0;
            vec_d       = vec_addr_s;
            state_d     = VEC_HI;
            if (fetch_src == 2'b01) begin
                epc_d = rd_valid_q ? inst_pc_q : pc_q;
            end else begin
                epc_d = epc_q;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                RUN: begin
                    if (branch_taken) begin
                        pc_d       = branch_target;
                        rd_valid_d = 1'b0;
                    end else if (stall) begin
                        imem_en_s = 1'b0;
                    end else begin
                        imem_en_s   = 1'b1;
                        imem_addr_s = pc_q[ADDR_W-1:0];
                        inst_pc_d   = pc_q;
                        pc_d        = pc_q + 32'd1;
                        rd_valid_d  = 1'b1;
                    end
                end
                VEC_HI: begin
                    imem_addr_s = vec_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    imem_en_s   = 1'b1;
                    lo_half_d   = imem_rdata;
                    state_d     = VEC_END;
                end
                VEC_END: begin
                    pc_d    = {imem_rdata, lo_half_q};
                    state_d = RUN;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign imem_addr  = imem_addr_s;
    assign imem_en    = imem_en_s;
    assign inst_out   = imem_rdata;
    assign inst_pc    = inst_pc_q;
    assign inst_valid = rd_valid_q & ~extend & ~fetch;
    assign epc        = epc_q;
    assign busy       = fetch | (state_q == VEC_HI) | (state_q == VEC_END);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed cycle script with a scoreboard of expected
// (pc, instruction) pairs checked by an independent monitor.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch = 1'b0;
    logic        extend = 1'b0;
    logic [1:0]  fetch_src = 2'b00;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic [15:0] imem_addr;
    logic        imem_en;
    logic [15:0] imem_rdata = 16'h0;
    logic [15:0] inst_out;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic [31:0] epc;
    logic        busy;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [15:0] inst;
    } exp_t;
    exp_t exp_q[$];

    logic [15:0] mem [0:65535];

    pc_fetch_unit #(.ADDR_W(16), .VEC_BASE(16'h0)) dut (
        .clk(clk), .rst(rst), .fetch(fetch), .extend(extend), .fetch_src(fetch_src),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_addr(imem_addr), .imem_en(imem_en), .imem_rdata(imem_rdata),
        .inst_out(inst_out), .inst_pc(inst_pc), .inst_valid(inst_valid),
        .epc(epc), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] pat(input logic [15:0] a);
        return a ^ 16'hC3A5;
    endfunction

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = pat(16'(i));
        mem[0] = 16'h0010; mem[1] = 16'h0000;
        mem[2] = 16'h0100; mem[3] = 16'h0001;
        mem[4] = 16'h0040; mem[5] = 16'h0000;
    end

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem[imem_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] p);
        exp_t e;
        e.pc   = p;
        e.inst = pat(p[15:0]);
        exp_q.push_back(e);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            nxt();
        end
    endtask

    // Monitor: every instruction accepted by decode must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst && inst_valid && !stall) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_inst: got pc %h inst %h expected none", inst_pc, inst_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("stream_pc", inst_pc, e.pc);
                chk("stream_inst", {16'h0, inst_out}, {16'h0, e.inst});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        nxt();
        @(negedge clk);
        chk("rst_en", {31'h0, imem_en}, 32'h0);
        chk("rst_valid", {31'h0, inst_valid}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_epc", epc, 32'h0);
        nxt();
        rst = 1'b0;

        // Reset vector load, then stream with a stall and two branches.
        for (int p = 32'h10; p <= 32'h16; p++) push(32'(p));
        push(32'h80); push(32'h81); push(32'h82); push(32'h1E); push(32'h1F);
        fetch = 1'b1; fetch_src = 2'b00;
        @(negedge clk);
        chk("c0_busy", {31'h0, busy}, 32'h1);
        chk("c0_en", {31'h0, imem_en}, 32'h1);
        chk("c0_addr", {16'h0, imem_addr}, 32'h0);
        nxt(); fetch = 1'b0;
        @(negedge clk);
        chk("c1_busy", {31'h0, busy}, 32'h1);
        chk("c1_addr", {16'h0, imem_addr}, 32'h1);
        nxt();
        @(negedge clk);
        chk("c2_busy", {31'h0, busy}, 32'h1);
        chk("c2_en", {31'h0, imem_en}, 32'h0);
        nxt();
        @(negedge clk);
        chk("c3_busy", {31'h0, busy}, 32'h0);
        chk("c3_addr", {16'h0, imem_addr}, 32'h10);
        chk("c3_valid", {31'h0, inst_valid}, 32'h0);
        nxt();
        run(3);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_en", {31'h0, imem_en}, 32'h0);
            chk("stall_valid", {31'h0, inst_valid}, 32'h1);
            chk("stall_pc", inst_pc, 32'h13);
            chk("stall_inst", {16'h0, inst_out}, {16'h0, pat(16'h13)});
            nxt();
        end
        stall = 1'b0;
        run(3);
        branch_taken = 1'b1; branch_target = 32'h80;
        @(negedge clk);
        chk("br_en", {31'h0, imem_en}, 32'h0);
        nxt(); branch_taken = 1'b0;
        @(negedge clk);
        chk("br_bubble", {31'h0, inst_valid}, 32'h0);
        nxt();
        run(2);
        branch_taken = 1'b1; branch_target = 32'h1E;
        run(1);
        branch_taken = 1'b0;
        @(negedge clk);
        chk("br2_bubble", {31'h0, inst_valid}, 32'h0);
        nxt();
        run(2);

        // Interrupt vector load while running at 0x20.
        push(32'h0001_0100);
        fetch = 1'b1; fetch_src = 2'b01;
        @(negedge clk);
        chk("irq_t0_valid", {31'h0, inst_valid}, 32'h0);
        chk("irq_t0_addr", {16'h0, imem_addr}, 32'h2);
        nxt(); fetch = 1'b0;
        @(negedge clk);
        chk("irq_t1_valid", {31'h0, inst_valid}, 32'h0);
        chk("irq_epc", epc, 32'h20);
        chk("irq_t1_addr", {16'h0, imem_addr}, 32'h3);
        nxt();
        @(negedge clk);
        chk("irq_t2_valid", {31'h0, inst_valid}, 32'h0);
        nxt();
        @(negedge clk);
        chk("irq_t3_valid", {31'h0, inst_valid}, 32'h0);
        chk("irq_t3_addr", {16'h0, imem_addr}, 32'h0100);
        nxt();
        run(1);

        // Fetch together with stall and branch: the vector load wins.
        push(32'h10); push(32'h11);
        fetch = 1'b1; fetch_src = 2'b00; stall = 1'b1;
        branch_taken = 1'b1; branch_target = 32'h80;
        @(negedge clk);
        chk("mix_addr", {16'h0, imem_addr}, 32'h0);
        chk("mix_busy", {31'h0, busy}, 32'h1);
        chk("mix_valid", {31'h0, inst_valid}, 32'h0);
        nxt(); fetch = 1'b0;
        @(negedge clk);
        chk("mix_hi_addr", {16'h0, imem_addr}, 32'h1);
        chk("mix_hi_en", {31'h0, imem_en}, 32'h1);
        nxt();
        @(negedge clk);
        chk("mix_epc", epc, 32'h20);
        nxt(); stall = 1'b0; branch_taken = 1'b0;
        @(negedge clk);
        chk("mix_issue", {16'h0, imem_addr}, 32'h10);
        nxt();
        run(2);

        // Reset asserted in VEC_HI, then a table-entry vector load.
        fetch = 1'b1; fetch_src = 2'b10;
        @(negedge clk);
        chk("t6_addr", {16'h0, imem_addr}, 32'h4);
        nxt(); fetch = 1'b0;
        @(negedge clk);
        chk("t6_hi_addr", {16'h0, imem_addr}, 32'h5);
        rst = 1'b1;
        #1;
        chk("t6_rst_en", {31'h0, imem_en}, 32'h0);
        chk("t6_rst_busy", {31'h0, busy}, 32'h0);
        chk("t6_rst_valid", {31'h0, inst_valid}, 32'h0);
        chk("t6_rst_epc", epc, 32'h0);
        chk("t6_rst_inst_pc", inst_pc, 32'h0);
        nxt();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_idle_en", {31'h0, imem_en}, 32'h0);
        nxt();
        push(32'h40); push(32'h41);
        fetch = 1'b1; fetch_src = 2'b10;
        @(negedge clk);
        chk("t6_re_addr", {16'h0, imem_addr}, 32'h4);
        nxt(); fetch = 1'b0;
        run(2);
        @(negedge clk);
        chk("t6_issue", {16'h0, imem_addr}, 32'h40);
        nxt();
        run(2);
        rst = 1'b1;
        run(2);
        chk("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
